// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM encoding,
// key-code width and row one-hot decoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  localparam int KEY_CODE_W = 4;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Index of the highest set bit; only meaningful for a one-hot input.
  function automatic logic [1:0] row_index(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and code-entry-side signals of the scanner, bundled.
// master = scanner, slave = keypad matrix / code-entry logic.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0]            ROW;
  logic                  A0;
  logic                  A1;
  logic                  EN;
  logic [KEY_CODE_W-1:0] KEY_CODE;
  logic                  KEY_VALID;
  logic                  KEY_DOWN;

  modport master (input ROW, output A0, A1, EN, KEY_CODE, KEY_VALID, KEY_DOWN);
  modport slave  (output ROW, input A0, A1, EN, KEY_CODE, KEY_VALID, KEY_DOWN);
endinterface

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running column dwell counter. FIRST and LAST are registered so they
// line up with count 0 and count SCAN_DIV-1 without decode glitches.
module scan_tick #(
  parameter int SCAN_DIV = 1000
) (
  input  logic CLK,
  input  logic RST,
  output logic FIRST,
  output logic LAST
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] r_count;
  logic          r_first;
  logic          r_last;

  // NOTE: state updates use <= so every flop samples pre-edge values; a
  // blocking assignment here would let later reads see the new count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
      r_first <= 1'b1;
      r_last  <= 1'b0;
    end else begin
      r_count <= (r_count == CW'(SCAN_DIV - 1)) ? '0 : r_count + CW'(1);
      r_first <= (r_count == CW'(SCAN_DIV - 1));
      r_last  <= (r_count == CW'(SCAN_DIV - 2));
    end
  end

  assign FIRST = r_first;
  assign LAST  = r_last;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the column decoder, debounces one key press and
// release, and reports the key code with a single-cycle valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  keypad_scanner_if.master  kp
);

  localparam int             DBW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DBW-1:0] DB_TARGET = DBW'(DEBOUNCE_CNT);

  logic                  w_first;
  logic                  w_last;
  logic [3:0]            r_sync1, r_sync2;
  state_t                r_state, w_state_nxt;
  logic [1:0]            r_col, w_col_nxt;
  logic [1:0]            r_row_idx, w_row_idx_nxt;
  logic [DBW-1:0]        r_match, w_match_nxt;
  logic [DBW-1:0]        r_release, w_release_nxt;
  logic [KEY_CODE_W-1:0] r_key_code, w_key_code_nxt;
  logic                  r_key_valid, w_key_valid_nxt;
  logic                  r_key_down, w_key_down_nxt;
  logic                  w_latch, w_accept, w_advance, w_release_done;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .CLK   (CLK),
    .RST   (RST),
    .FIRST (w_first),
    .LAST  (w_last)
  );

  wire            w_one_hot     = is_one_hot(r_sync2);
  wire [1:0]      w_sample_idx  = row_index(r_sync2);
  wire            w_same        = (r_sync2 == (4'b0001 << r_row_idx));
  wire            w_row_low     = ~r_sync2[r_row_idx];
  wire [DBW-1:0]  w_match_inc   = r_match + DBW'(1);
  wire [DBW-1:0]  w_release_inc = r_release + DBW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_SCAN;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_latch        = 1'b0;
    w_accept       = 1'b0;
    w_advance      = 1'b0;
    w_release_done = 1'b0;
    if (w_last) begin
      case (r_state)
        ST_SCAN: begin
          if (w_one_hot) begin
            w_latch = 1'b1;
            if (DEBOUNCE_CNT == 1) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = ST_DEBOUNCE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_same) begin
            w_advance   = 1'b1;
            w_state_nxt = ST_SCAN;
          end else if (w_match_inc == DB_TARGET) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_row_low && (w_release_inc == DB_TARGET)) begin
            w_release_done = 1'b1;
            w_advance      = 1'b1;
            w_state_nxt    = ST_SCAN;
          end
        end
        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  // On accept the sample equals the latched one-hot, so its index is the key row.
  always_comb begin
    w_col_nxt       = w_advance ? r_col + 2'd1 : r_col;
    w_row_idx_nxt   = w_latch ? w_sample_idx : r_row_idx;
    w_key_valid_nxt = w_accept;
    w_key_code_nxt  = w_accept ? {r_col, w_sample_idx} : r_key_code;
    w_key_down_nxt  = w_accept ? 1'b1 : (w_release_done ? 1'b0 : r_key_down);

    w_match_nxt = r_match;
    if (w_latch)                                  w_match_nxt = DBW'(1);
    else if (w_last && r_state == ST_DEBOUNCE)    w_match_nxt = w_same ? w_match_inc : '0;
    if (w_accept)                                 w_match_nxt = '0;

    w_release_nxt = r_release;
    if (w_last && r_state == ST_HOLD)             w_release_nxt = w_row_low ? w_release_inc : '0;
    if (w_accept || w_release_done)               w_release_nxt = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_col       <= '0;
      r_row_idx   <= '0;
      r_match     <= '0;
      r_release   <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_sync1     <= kp.ROW;
      r_sync2     <= r_sync1;
      r_col       <= w_col_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_match     <= w_match_nxt;
      r_release   <= w_release_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_down  <= w_key_down_nxt;
    end
  end

  assign kp.A0        = r_col[1];
  assign kp.A1        = r_col[0];
  assign kp.EN        = w_first;
  assign kp.KEY_CODE  = r_key_code;
  assign kp.KEY_VALID = r_key_valid;
  assign kp.KEY_DOWN  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives ROW
// from the selected column, a sample-point model predicts every output.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .CLK (CLK),
    .RST (RST),
    .kp  (kp)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: a pressed key connects its rows only while its column is driven.
  logic       key_on   = 1'b0;
  logic [1:0] key_col  = 2'd0;
  logic [3:0] key_rows = 4'b0000;
  assign kp.ROW = (key_on && ({kp.A0, kp.A1} == key_col) && !kp.EN) ? key_rows : 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dut_col();
    return {kp.A0, kp.A1};
  endfunction

  // Model: decisions are made only at sample points from ROW two cycles back.
  int         m_cnt, m_col, m_streak, m_quiet;
  logic [3:0] m_cand, h0, h1, h2;
  logic       e_valid, e_down;
  logic [3:0] e_code;

  task automatic model_reset();
    m_cnt = 0; m_col = 0; m_streak = 0; m_quiet = 0;
    m_cand = '0; h0 = '0; h1 = '0; h2 = '0;
    e_valid = 1'b0; e_down = 1'b0; e_code = '0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    e_valid = 1'b0;
    if (m_cnt == SCAN_DIV - 1) begin
      s = h2;
      if (!e_down) begin
        if (m_streak == 0) begin
          if ($countones(s) == 1) begin m_cand = s; m_streak = 1; end
          else m_col = (m_col + 1) % 4;
        end else if (s == m_cand) begin
          m_streak++;
        end else begin
          m_streak = 0;
          m_col = (m_col + 1) % 4;
        end
        if (m_streak == DEBOUNCE_CNT) begin
          e_valid = 1'b1; e_down = 1'b1;
          e_code = 4'(m_col * 4 + $clog2(m_cand));
          m_streak = 0; m_quiet = 0;
        end
      end else begin
        m_quiet = ((s & m_cand) == 4'b0000) ? m_quiet + 1 : 0;
        if (m_quiet == DEBOUNCE_CNT) begin
          e_down = 1'b0; m_quiet = 0;
          m_col = (m_col + 1) % 4;
        end
      end
    end
    m_cnt = (m_cnt + 1) % SCAN_DIV;
  endtask

  always @(negedge CLK) begin
    if (kp.KEY_VALID) n_pulses++;
    if (RST) begin
      model_reset();
      check("rst_col",   32'(dut_col()),    32'd0);
      check("rst_en",    32'(kp.EN),        32'd1);
      check("rst_valid", 32'(kp.KEY_VALID), 32'd0);
      check("rst_down",  32'(kp.KEY_DOWN),  32'd0);
      check("rst_code",  32'(kp.KEY_CODE),  32'd0);
    end else begin
      h2 = h1; h1 = h0; h0 = kp.ROW;
      check("col",   32'(dut_col()),    32'(m_col));
      check("en",    32'(kp.EN),        32'(m_cnt == 0));
      check("valid", 32'(kp.KEY_VALID), 32'(e_valid));
      check("down",  32'(kp.KEY_DOWN),  32'(e_down));
      check("code",  32'(kp.KEY_CODE),  32'(e_code));
      model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_dwell(input logic [1:0] c, input string name);
    int n;
    n = 0;
    while (!(dut_col() == c && kp.EN) && n < 64) begin
      step(1);
      n++;
    end
    check({name, "_dwell_reached"}, 32'(dut_col() == c && kp.EN), 32'd1);
  endtask

  int first, pulses, col_bad, down_bad, p0;

  initial begin
    step(3);
    RST = 1'b0;

    // 1: idle scan, each column held SCAN_DIV cycles, EN only on the first.
    for (int i = 0; i < 5; i++) begin
      check("t1_col", 32'(dut_col()), 32'(i % 4));
      check("t1_en_first", 32'(kp.EN), 32'd1);
      step(1);
      check("t1_en_mid", 32'(kp.EN), 32'd0);
      step(3);
    end
    check("t1_no_valid", n_pulses, 0);

    // 2: key at column 10, row 1, held for 200 cycles.
    wait_dwell(2'd2, "t2");
    key_col = 2'd2; key_rows = 4'b0010; key_on = 1'b1;
    first = -1; pulses = 0; col_bad = 0; down_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (kp.KEY_VALID) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (dut_col() != 2'd2) col_bad++;
      if (i >= 12 && !kp.KEY_DOWN) down_bad++;
      step(1);
    end
    check("t2_valid_latency", 32'(first), 32'd12);
    check("t2_one_pulse", 32'(pulses), 32'd1);
    check("t2_col_frozen", 32'(col_bad), 32'd0);
    check("t2_down_held", 32'(down_bad), 32'd0);
    check("t2_code", 32'(kp.KEY_CODE), 32'b1001);

    // 4: release with a one-dwell bounce; only 3 consecutive zeros release.
    check("t4_dwell_start", 32'(kp.EN), 32'd1);
    key_on = 1'b0; step(8);
    key_on = 1'b1; step(4);
    key_on = 1'b0; step(7);
    check("t4_down_after_bounce", 32'(kp.KEY_DOWN), 32'd1);
    step(4);
    check("t4_down_last", 32'(kp.KEY_DOWN), 32'd1);
    step(1);
    check("t4_down_fell", 32'(kp.KEY_DOWN), 32'd0);
    check("t4_col_next", 32'(dut_col()), 32'd3);

    // 3: single matching sample then bounce away.
    wait_dwell(2'd2, "t3");
    p0 = n_pulses;
    key_col = 2'd2; key_rows = 4'b0010; key_on = 1'b1;
    step(4);
    key_on = 1'b0;
    check("t3_col_frozen", 32'(dut_col()), 32'd2);
    step(4);
    check("t3_col_resume", 32'(dut_col()), 32'd3);
    step(8);
    check("t3_no_valid", 32'(n_pulses - p0), 32'd0);
    check("t3_code_kept", 32'(kp.KEY_CODE), 32'b1001);

    // 5: two rows at once on column 01 is ignored.
    wait_dwell(2'd1, "t5");
    p0 = n_pulses;
    key_col = 2'd1; key_rows = 4'b0011; key_on = 1'b1;
    step(4);
    check("t5_col_advanced", 32'(dut_col()), 32'd2);
    step(16);
    key_on = 1'b0;
    check("t5_no_valid", 32'(n_pulses - p0), 32'd0);
    check("t5_not_down", 32'(kp.KEY_DOWN), 32'd0);

    // 6: async reset during HOLD, then re-detection of the still-held key.
    wait_dwell(2'd3, "t6");
    key_col = 2'd3; key_rows = 4'b1000; key_on = 1'b1;
    step(20);
    check("t6_holding", 32'(kp.KEY_DOWN), 32'd1);
    check("t6_code", 32'(kp.KEY_CODE), 32'b1111);
    p0 = n_pulses;
    #2 RST = 1'b1;
    #1;
    check("t6_async_col",   32'(dut_col()),    32'd0);
    check("t6_async_en",    32'(kp.EN),        32'd1);
    check("t6_async_valid", 32'(kp.KEY_VALID), 32'd0);
    check("t6_async_down",  32'(kp.KEY_DOWN),  32'd0);
    check("t6_async_code",  32'(kp.KEY_CODE),  32'd0);
    step(2);
    RST = 1'b0;
    check("t6_no_pulse_in_reset", 32'(n_pulses - p0), 32'd0);
    first = -1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (kp.KEY_VALID) begin
        pulses++;
        if (first < 0) first = i;
      end
      step(1);
    end
    check("t6_redetect_latency", 32'(first), 32'd24);
    check("t6_redetect_once", 32'(pulses), 32'd1);
    check("t6_redetect_code", 32'(kp.KEY_CODE), 32'b1111);
    key_on = 1'b0;
    step(40);
    check("t6_released", 32'(kp.KEY_DOWN), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
